alu_rs_pool: RTL and testbench
==============================

ALU_RS_POOL -- requirements
Module: alu_rs_pool

Interface
REQ-001 Parameter DATA_WIDTH, 16, operand/result width.
REQ-002 Parameter TAG_WIDTH, 3, ROB/producer tag width.
REQ-003 Parameter DEPTH, 4, number of station entries (2..16).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  mispredict flush; synchronous, same effect as reset on entry state.
REQ-007 issue_valid  in  1  issue request; issue_ready  out  1  a free entry exists.
REQ-008 issue_op  in  lc3b_opcode; issue_dest  in  TAG_WIDTH  destination tag.
REQ-009 issue_Vj, issue_Vk  in  DATA_WIDTH  operand values; issue_Qj, issue_Qk  in  TAG_WIDTH  producer tags.
REQ-010 issue_Qj_valid, issue_Qk_valid  in  1  operand still pending on the tag.
REQ-011 cdb_in  in  CDB  broadcast bus (valid, tag, data) snooped by every entry.
REQ-012 disp_valid  out  1; disp_ready  in  1; disp_op, disp_a, disp_b, disp_dest  out  operation to ALU.
REQ-013 busy_out  out  DEPTH  per-entry busy bits; count_out  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-014 Issue fires when issue_valid && issue_ready; entry written is the lowest-index free entry.
REQ-015 issue_ready SHALL be 1 iff count_out < DEPTH, computed from registered state only (no dispatch look-ahead).
REQ-016 Entry operand pending with cdb_in.valid && cdb_in.tag == Q SHALL capture cdb_in.data and clear its pending flag at that edge.
REQ-017 Issue-cycle CDB bypass: if issue_Q*_valid and cdb_in matches issue_Q* in the same cycle, operand is stored captured, not pending.
REQ-018 Entry ready = busy && !Qj pending && !Qk pending, from registered state (capture to dispatch latency one cycle minimum).
REQ-019 Selection: oldest ready entry; age kept as per-entry sequence stamp from an issue counter, compared modulo-wrap, or an age matrix.
REQ-020 disp_* SHALL be combinational from the selected entry; disp_valid = any entry ready.
REQ-021 On disp_valid && disp_ready the selected entry's busy clears at that edge; entry reusable by issue next cycle.
REQ-022 Issue and dispatch in the same cycle are both accepted; count_out unchanged net.
REQ-023 When disp_ready is low, selected entry holds and disp_* stay stable until accepted unless flushed.
REQ-024 flush SHALL clear all busy bits at the edge; issue and dispatch in that cycle are discarded.
REQ-025 Age wrap: ordering SHALL remain correct after more than 2^k issues (counter width >= $clog2(DEPTH)+1).
REQ-026 Both operands pending on the same tag SHALL both capture from one broadcast.

Reset
REQ-027 After reset: all busy 0, count_out 0, issue_ready 1, disp_valid 0, age counter 0.
REQ-028 Reset asserted mid-operation SHALL behave as REQ-027 at the next edge regardless of other inputs; reset dominates flush.

Structure
REQ-029 CDB struct and lc3b_opcode come from lc3b_types; add rs_entry_t (busy, op, Vj, Vk, Qj, Qk, pending flags, dest, age) there.
REQ-030 One sub-module: rs_oldest_select (combinational DEPTH-way ready/age picker returning index and valid).

Verification
REQ-031 Issue ADD Vj=5,Vk=3 no pending, disp_ready=1 -> disp_valid next cycle, disp_a=5, disp_b=3, entry freed.
REQ-032 Issue entry Qj=2 pending; CDB tag 2 data 0x1234 two cycles later -> dispatch one cycle after capture, disp_a=0x1234.
REQ-033 Fill DEPTH entries with disp_ready=0 -> issue_ready=0, count_out=DEPTH; one dispatch -> issue_ready=1 next cycle.
REQ-034 Issue A (pending tag 4), then B (ready); broadcast tag 4 -> B dispatches first, then A; with both ready, older A first.
REQ-035 Issue with Qk=6 while CDB broadcasts tag 6 data 0x00FF same cycle -> entry ready, disp_b=0x00FF.
REQ-036 Three entries busy, assert flush with issue_valid=1 -> all busy 0, count_out 0, no entry from that issue.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b out-of-order core: opcodes, CDB bus and
// reservation-station entry layout.
package lc3b_types;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;
    localparam int AGE_W  = 5;

    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic              busy;
        lc3b_opcode        op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic              qj_p;
        logic              qk_p;
        logic [TAG_W-1:0]  dest;
        logic [AGE_W-1:0]  age;
    } rs_entry_t;

    // a is older than b when a-b is negative modulo 2^AGE_W
    function automatic logic age_older(
        input logic [AGE_W-1:0] a,
        input logic [AGE_W-1:0] b
    );
        logic [AGE_W-1:0] d;
        d = a - b;
        return d[AGE_W-1];
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational picker: returns the index of the oldest ready entry.
module rs_oldest_select
    import lc3b_types::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            ready_i,
    input  logic [DEPTH-1:0][AGE_W-1:0] ages_i,
    output logic [IW-1:0]               idx_o,
    output logic                        valid_o
);

    logic             found;
    logic [AGE_W-1:0] best;
    logic [IW-1:0]    idx;

    always_comb begin
        found = 1'b0;
        best  = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && (!found || age_older(ages_i[i], best))) begin
                found = 1'b1;
                best  = ages_i[i];
                idx   = i[IW-1:0];
            end
        end
    end

    assign idx_o   = idx;
    assign valid_o = found;

endmodule

// File: rtl/alu_rs_pool.sv
// ALU reservation-station pool: tag-snooping entries with oldest-ready
// dispatch and a hold lock while the ALU stalls.
module alu_rs_pool
    import lc3b_types::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  lc3b_opcode            issue_op,
    input  logic [TAG_WIDTH-1:0]  issue_dest,
    input  logic [DATA_WIDTH-1:0] issue_Vj,
    input  logic [DATA_WIDTH-1:0] issue_Vk,
    input  logic [TAG_WIDTH-1:0]  issue_Qj,
    input  logic [TAG_WIDTH-1:0]  issue_Qk,
    input  logic                  issue_Qj_valid,
    input  logic                  issue_Qk_valid,
    input  cdb_t                  cdb_in,
    output logic                  disp_valid,
    input  logic                  disp_ready,
    output lc3b_opcode            disp_op,
    output logic [DATA_WIDTH-1:0] disp_a,
    output logic [DATA_WIDTH-1:0] disp_b,
    output logic [TAG_WIDTH-1:0]  disp_dest,
    output logic [DEPTH-1:0]      busy_out,
    output logic [CW-1:0]         count_out
);

    localparam int IW = $clog2(DEPTH);

    rs_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [AGE_W-1:0]      age_q, age_d;
    logic                  lock_q, lock_d;
    logic [IW-1:0]         lock_idx_q, lock_idx_d;

    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0][AGE_W-1:0] ages;
    logic [IW-1:0]               sel_idx, pick_idx, free_idx;
    logic                        sel_v, free_v;
    logic                        issue_fire, disp_fire;
    logic [CW-1:0]               cnt;
    rs_entry_t                   pick, new_ent;

    always_comb begin
        cnt      = '0;
        free_v   = 1'b0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_out[i] = ent_q[i].busy;
            ages[i]     = ent_q[i].age;
            rdy[i]      = ent_q[i].busy && !ent_q[i].qj_p && !ent_q[i].qk_p;
            cnt         = cnt + CW'(ent_q[i].busy);
            if (!ent_q[i].busy && !free_v) begin
                free_v   = 1'b1;
                free_idx = i[IW-1:0];
            end
        end
    end

    rs_oldest_select #(.DEPTH(DEPTH), .IW(IW)) u_sel (
        .ready_i (rdy),
        .ages_i  (ages),
        .idx_o   (sel_idx),
        .valid_o (sel_v)
    );

    // A stalled pick stays locked so disp_* cannot change under the ALU
    assign pick_idx    = lock_q ? lock_idx_q : sel_idx;
    assign pick        = ent_q[pick_idx];
    assign disp_valid  = lock_q || sel_v;
    assign disp_op     = pick.op;
    assign disp_a      = pick.vj;
    assign disp_b      = pick.vk;
    assign disp_dest   = pick.dest;
    assign count_out   = cnt;
    assign issue_ready = free_v;
    assign issue_fire  = issue_valid && issue_ready && !flush;
    assign disp_fire   = disp_valid && disp_ready;

    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = issue_op;
        new_ent.vj   = issue_Vj;
        new_ent.vk   = issue_Vk;
        new_ent.qj   = issue_Qj;
        new_ent.qk   = issue_Qk;
        new_ent.qj_p = issue_Qj_valid;
        new_ent.qk_p = issue_Qk_valid;
        new_ent.dest = issue_dest;
        new_ent.age  = age_q;
        if (issue_Qj_valid && cdb_in.valid && cdb_in.tag == issue_Qj) begin
            new_ent.vj   = cdb_in.data;
            new_ent.qj_p = 1'b0;
        end
        if (issue_Qk_valid && cdb_in.valid && cdb_in.tag == issue_Qk) begin
            new_ent.vk   = cdb_in.data;
            new_ent.qk_p = 1'b0;
        end
    end

    always_comb begin
        ent_d      = ent_q;
        age_d      = age_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_in.valid && ent_q[i].busy) begin
                if (ent_q[i].qj_p && ent_q[i].qj == cdb_in.tag) begin
                    ent_d[i].vj   = cdb_in.data;
                    ent_d[i].qj_p = 1'b0;
                end
                if (ent_q[i].qk_p && ent_q[i].qk == cdb_in.tag) begin
                    ent_d[i].vk   = cdb_in.data;
                    ent_d[i].qk_p = 1'b0;
                end
            end
        end
        if (disp_fire) begin
            ent_d[pick_idx].busy = 1'b0;
        end else if (disp_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = pick_idx;
        end
        if (issue_fire) begin
            ent_d[free_idx] = new_ent;
            age_d           = age_q + AGE_W'(1);
        end
        if (flush) begin
            lock_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q      <= '0;
            age_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ent_q      <= ent_d;
            age_q      <= age_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_alu_rs_pool.sv
// Scoreboard bench for alu_rs_pool: directed issue/CDB sequences, a monitor
// checks each accepted dispatch against the expected queue.
module tb_alu_rs_pool;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        issue_valid, issue_ready;
    lc3b_opcode  issue_op;
    logic [2:0]  issue_dest, issue_Qj, issue_Qk;
    logic [15:0] issue_Vj, issue_Vk;
    logic        issue_Qj_valid, issue_Qk_valid;
    cdb_t        cdb_in;
    logic        disp_valid, disp_ready;
    lc3b_opcode  disp_op;
    logic [15:0] disp_a, disp_b;
    logic [2:0]  disp_dest;
    logic [3:0]  busy_out;
    logic [2:0]  count_out;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_issued = 0;

    always #5 clk = ~clk;

    alu_rs_pool #(.DATA_WIDTH(16), .TAG_WIDTH(3), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_op       (issue_op),
        .issue_dest     (issue_dest),
        .issue_Vj       (issue_Vj),
        .issue_Vk       (issue_Vk),
        .issue_Qj       (issue_Qj),
        .issue_Qk       (issue_Qk),
        .issue_Qj_valid (issue_Qj_valid),
        .issue_Qk_valid (issue_Qk_valid),
        .cdb_in         (cdb_in),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_op        (disp_op),
        .disp_a         (disp_a),
        .disp_b         (disp_b),
        .disp_dest      (disp_dest),
        .busy_out       (busy_out),
        .count_out      (count_out)
    );

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && disp_valid && disp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch got a=%h b=%h exp none",
                         disp_a, disp_b);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("disp_op", 32'(disp_op), 32'(e.op));
                chk("disp_a", 32'(disp_a), 32'(e.a));
                chk("disp_b", 32'(disp_b), 32'(e.b));
                chk("disp_dest", 32'(disp_dest), 32'(e.dest));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input lc3b_opcode op, input logic [2:0] d,
                         input logic [15:0] vj, input logic [15:0] vk,
                         input logic [2:0] qj, input logic qjv,
                         input logic [2:0] qk, input logic qkv);
        issue_valid    = 1'b1;
        issue_op       = op;
        issue_dest     = d;
        issue_Vj       = vj;
        issue_Vk       = vk;
        issue_Qj       = qj;
        issue_Qj_valid = qjv;
        issue_Qk       = qk;
        issue_Qk_valid = qkv;
        if (!flush && !reset) n_issued++;
        cyc(1);
        issue_valid = 1'b0;
    endtask

    task automatic push(input lc3b_opcode op, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] d);
        exp_t e;
        e.op = 4'(op); e.a = a; e.b = b; e.dest = d;
        sbq.push_back(e);
    endtask

    task automatic bcast(input logic [2:0] t, input logic [15:0] v);
        cdb_in.valid = 1'b1;
        cdb_in.tag   = t;
        cdb_in.data  = v;
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_busy"}, 32'(busy_out), 32'h0);
        chk({n, "_count"}, 32'(count_out), 32'h0);
        chk({n, "_issue_ready"}, 32'(issue_ready), 32'h1);
        chk({n, "_disp_valid"}, 32'(disp_valid), 32'h0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; disp_ready = 1'b0;
        issue_op = op_add; issue_dest = '0; issue_Vj = '0; issue_Vk = '0;
        issue_Qj = '0; issue_Qk = '0; issue_Qj_valid = 1'b0;
        issue_Qk_valid = 1'b0; cdb_in = '0;
        cyc(2);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        #4;

        // simple ready ADD dispatches the next cycle
        disp_ready = 1'b1;
        push(op_add, 16'd5, 16'd3, 3'd1);
        issue(op_add, 3'd1, 16'd5, 16'd3, 3'd0, 1'b0, 3'd0, 1'b0);
        cyc(1);
        chk("t1_freed", 32'(count_out), 32'h0);

        // operand waits on tag 2, captured two cycles later
        issue(op_and, 3'd2, 16'hBEEF, 16'd7, 3'd2, 1'b1, 3'd0, 1'b0);
        @(negedge clk);
        chk("t2_wait", 32'(disp_valid), 32'h0);
        @(posedge clk); #1;
        bcast(3'd2, 16'h1234);
        push(op_and, 16'h1234, 16'd7, 3'd2);
        @(negedge clk);
        chk("t2_capture_cycle", 32'(disp_valid), 32'h0);
        @(posedge clk); #1;
        cdb_in = '0;
        cyc(1);

        // fill all entries with the ALU stalled
        disp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(op_add, 16'h00A0 + 16'(i), 16'(i), 3'(i));
            issue(op_add, 3'(i), 16'h00A0 + 16'(i), 16'(i), 3'd0, 1'b0,
                  3'd0, 1'b0);
        end
        @(negedge clk);
        chk("t3_full_ready", 32'(issue_ready), 32'h0);
        chk("t3_full_count", 32'(count_out), 32'd4);
        chk("t3_full_busy", 32'(busy_out), 32'hF);
        chk("t3_hold_a", 32'(disp_a), 32'h00A0);
        @(posedge clk); #1;
        disp_ready = 1'b1;
        cyc(1);
        disp_ready = 1'b0;
        chk("t3_after_ready", 32'(issue_ready), 32'h1);
        chk("t3_after_count", 32'(count_out), 32'd3);
        disp_ready = 1'b1;
        cyc(4);
        chk("t3_drained", 32'(count_out), 32'h0);

        // younger ready B overtakes older pending A
        issue(op_add, 3'd3, 16'h0000, 16'd10, 3'd4, 1'b1, 3'd0, 1'b0);
        push(op_and, 16'd20, 16'd21, 3'd4);
        issue(op_and, 3'd4, 16'd20, 16'd21, 3'd0, 1'b0, 3'd0, 1'b0);
        cyc(1);
        bcast(3'd4, 16'h0044);
        push(op_add, 16'h0044, 16'd10, 3'd3);
        cyc(1);
        cdb_in = '0;
        cyc(2);

        // run the age counter up to the wrap point
        while (n_issued < 31) begin
            push(op_not, 16'(n_issued), 16'hFFFF, 3'd5);
            issue(op_not, 3'd5, 16'(n_issued), 16'hFFFF, 3'd0, 1'b0,
                  3'd0, 1'b0);
        end
        cyc(2);
        chk("wrap_prep_count", 32'(count_out), 32'h0);

        // older C (stamp 31) must precede younger D (stamp 0 after wrap)
        disp_ready = 1'b0;
        issue(op_shf, 3'd6, 16'h0C0C, 16'd1, 3'd0, 1'b0, 3'd0, 1'b0);
        issue(op_lea, 3'd7, 16'h0D0D, 16'd2, 3'd0, 1'b0, 3'd0, 1'b0);
        push(op_shf, 16'h0C0C, 16'd1, 3'd6);
        push(op_lea, 16'h0D0D, 16'd2, 3'd7);
        disp_ready = 1'b1;
        cyc(3);

        // same-cycle CDB bypass on Qk
        bcast(3'd6, 16'h00FF);
        push(op_add, 16'h0011, 16'h00FF, 3'd1);
        issue(op_add, 3'd1, 16'h0011, 16'hDEAD, 3'd0, 1'b0, 3'd6, 1'b1);
        cdb_in = '0;
        cyc(2);

        // both operands wait on the same tag
        issue(op_and, 3'd2, 16'h1111, 16'h2222, 3'd5, 1'b1, 3'd5, 1'b1);
        bcast(3'd5, 16'h0055);
        push(op_and, 16'h0055, 16'h0055, 3'd2);
        cyc(1);
        cdb_in = '0;
        cyc(2);

        // flush with a concurrent issue discards everything
        disp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(op_add, 3'(i), 16'h0F00, 16'(i), 3'd0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        chk("t6_pre_count", 32'(count_out), 32'd3);
        @(posedge clk); #1;
        flush = 1'b1;
        issue(op_add, 3'd7, 16'hAAAA, 16'hBBBB, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        chk_idle("flush");
        @(posedge clk); #1;
        disp_ready = 1'b1;
        cyc(3);

        // reset mid-operation dominates flush and issue
        disp_ready = 1'b0;
        issue(op_add, 3'd1, 16'h0001, 16'h0002, 3'd0, 1'b0, 3'd0, 1'b0);
        issue(op_add, 3'd2, 16'h0003, 16'h0004, 3'd3, 1'b1, 3'd0, 1'b0);
        reset = 1'b1;
        flush = 1'b1;
        issue(op_add, 3'd3, 16'h0005, 16'h0006, 3'd0, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        @(posedge clk); #1;
        disp_ready = 1'b1;
        push(op_jmp, 16'h7777, 16'h8888, 3'd0);
        issue(op_jmp, 3'd0, 16'h7777, 16'h8888, 3'd0, 1'b0, 3'd0, 1'b0);
        cyc(3);

        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
